// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Entry layout, regfile-select constant and parameter legality helper.
package hazard_scoreboard_pkg;

  localparam int unsigned HAZ_SEL_RF = 0;
  localparam int unsigned HAZ_REG_W  = 5;

  typedef struct packed {
    logic                 valid;
    logic [HAZ_REG_W-1:0] req_w;
    logic                 is_load;
  } haz_entry_t;

  function automatic bit haz_params_legal(input int stages, input int load_lat,
                                          input int sel_bit);
    return (stages >= 2) && (load_lat >= 1) && (load_lat < stages) &&
           (sel_bit >= $clog2(stages + 1));
  endfunction

endpackage

// File: rtl/haz_match_prio.sv
// Priority match of one ID source operand against the in-flight scoreboard entries.
// The youngest matching entry (smallest index) wins.
module haz_match_prio
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int SEL_BIT = 2
) (
  input  logic                 use_src,
  input  logic [HAZ_REG_W-1:0] req,
  input  haz_entry_t [STAGES:1] entries,
  output logic                 hit,
  output logic [SEL_BIT-1:0]   sel,
  output logic                 is_load_hit
);

  // Walk oldest to youngest so the youngest match is the last one assigned.
  always_comb begin
    hit         = 1'b0;
    sel         = SEL_BIT'(HAZ_SEL_RF);
    is_load_hit = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (use_src && (req != '0) && entries[k].valid && (entries[k].req_w == req)) begin
        hit         = 1'b1;
        sel         = SEL_BIT'(k);
        is_load_hit = entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside the ID stage: forwarding selects, load-use stall, flush.
// Optional HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt event counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_BIT  = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [HAZ_REG_W-1:0] id_req_a,
  input  logic [HAZ_REG_W-1:0] id_req_b,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 id_w_en,
  input  logic [HAZ_REG_W-1:0] id_req_w,
  input  logic                 id_is_load,
  input  logic                 load_pc,
  output logic [SEL_BIT-1:0]   fwd_sel_a,
  output logic [SEL_BIT-1:0]   fwd_sel_b,
  output logic                 stall,
`ifdef HAZ_PERF_CNT_EN
  output logic                 flush,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`else
  output logic                 flush
`endif
);

  if (!haz_params_legal(STAGES, LOAD_LAT, SEL_BIT)) begin : g_bad_params
    $error("hazard_scoreboard: need STAGES >= 2, 1 <= LOAD_LAT < STAGES, wide SEL_BIT");
  end

  haz_entry_t [STAGES:1] entries_q, entries_d;

  logic               hit_a, hit_b;
  logic               load_a, load_b;
  logic [SEL_BIT-1:0] sel_a, sel_b;
  logic               use_stall_a, use_stall_b;
  logic               stall_raw;

  haz_match_prio #(
    .STAGES (STAGES),
    .SEL_BIT(SEL_BIT)
  ) u_match_a (
    .use_src    (id_use_a),
    .req        (id_req_a),
    .entries    (entries_q),
    .hit        (hit_a),
    .sel        (sel_a),
    .is_load_hit(load_a)
  );

  haz_match_prio #(
    .STAGES (STAGES),
    .SEL_BIT(SEL_BIT)
  ) u_match_b (
    .use_src    (id_use_b),
    .req        (id_req_b),
    .entries    (entries_q),
    .hit        (hit_b),
    .sel        (sel_b),
    .is_load_hit(load_b)
  );

  // Only the winning entry matters: a younger non-load hit masks an older load.
  always_comb begin
    use_stall_a = hit_a && load_a && (int'(sel_a) <= LOAD_LAT);
    use_stall_b = hit_b && load_b && (int'(sel_b) <= LOAD_LAT);
    stall_raw   = !load_pc && (use_stall_a || use_stall_b);
  end

  always_comb begin
    fwd_sel_a = rst ? '0 : sel_a;
    fwd_sel_b = rst ? '0 : sel_b;
    stall     = rst ? 1'b0 : stall_raw;
    flush     = rst ? 1'b0 : load_pc;
  end

  always_comb begin
    entries_d = entries_q;
    if (en) begin
      for (int k = STAGES; k >= 2; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      // A stalled or squashed ID instruction enters as a bubble.
      entries_d[1].valid   = id_w_en && (id_req_w != '0) && !stall_raw && !load_pc;
      entries_d[1].req_w   = id_req_w;
      entries_d[1].is_load = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (en) begin
      if (stall_raw) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (load_pc)   flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed pipeline scenarios plus randomized traffic vs. an issue-history model.
// Runs a STAGES=3/LOAD_LAT=1 and a STAGES=4/LOAD_LAT=2 instance off the same ID inputs.
module tb_hazard_scoreboard;

  typedef struct {
    bit       wr;
    bit [4:0] rd;
    bit       ld;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst, en, id_use_a, id_use_b, id_w_en, id_is_load, load_pc;
  logic [4:0] id_req_a, id_req_b, id_req_w;
  logic [1:0] sel3_a, sel3_b;
  logic [2:0] sel4_a, sel4_b;
  logic       stall3, flush3, stall4, flush4;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc3, fc3, sc4, fc4;
  logic [31:0] exp_sc3 = 0, exp_fc3 = 0, exp_sc4 = 0, exp_fc4 = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Issue history, youngest first: element i is the instruction i+1 stages past ID.
  instr_t hist3[$];
  instr_t hist4[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.STAGES(3), .LOAD_LAT(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .id_req_a(id_req_a), .id_req_b(id_req_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_w_en(id_w_en), .id_req_w(id_req_w),
    .id_is_load(id_is_load), .load_pc(load_pc), .fwd_sel_a(sel3_a), .fwd_sel_b(sel3_b),
    .stall(stall3), .flush(flush3)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  hazard_scoreboard #(.STAGES(4), .LOAD_LAT(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .id_req_a(id_req_a), .id_req_b(id_req_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_w_en(id_w_en), .id_req_w(id_req_w),
    .id_is_load(id_is_load), .load_pc(load_pc), .fwd_sel_a(sel4_a), .fwd_sel_b(sel4_b),
    .stall(stall4), .flush(flush4)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(sc4), .flush_cnt(fc4)
`endif
  );

  function automatic int exp_sel(input instr_t h[$], input int stages, input bit use_s,
                                 input bit [4:0] r);
    if (!use_s || r == 0) return 0;
    for (int k = 1; k <= stages && k <= h.size(); k++) begin
      if (h[k-1].wr && h[k-1].rd == r) return k;
    end
    return 0;
  endfunction

  function automatic bit exp_stall(input instr_t h[$], input int stages, input int lat);
    int sa, sb;
    if (load_pc) return 1'b0;
    sa = exp_sel(h, stages, id_use_a, id_req_a);
    sb = exp_sel(h, stages, id_use_b, id_req_b);
    return (sa != 0 && h[sa-1].ld && sa <= lat) || (sb != 0 && h[sb-1].ld && sb <= lat);
  endfunction

  task automatic drive(input bit ua, input bit [4:0] ra, input bit ub, input bit [4:0] rb,
                       input bit w, input bit [4:0] rw, input bit ld, input bit lpc);
    id_use_a = ua; id_req_a = ra; id_use_b = ub; id_req_b = rb;
    id_w_en = w; id_req_w = rw; id_is_load = ld; load_pc = lpc;
  endtask

  // One clock edge; the history model advances from the rules, not from the DUT.
  task automatic tick();
    bit s3, s4;
    instr_t n, bub;
    s3 = exp_stall(hist3, 3, 1);
    s4 = exp_stall(hist4, 4, 2);
    n.wr = id_w_en && id_req_w != 0; n.rd = id_req_w; n.ld = id_is_load;
    bub.wr = 1'b0; bub.rd = 5'd0; bub.ld = 1'b0;
    @(posedge clk);
    if (rst) begin
      hist3.delete();
      hist4.delete();
`ifdef HAZ_PERF_CNT_EN
      exp_sc3 = 0; exp_fc3 = 0; exp_sc4 = 0; exp_fc4 = 0;
`endif
    end else if (en) begin
      if (s3 || load_pc) hist3.push_front(bub); else hist3.push_front(n);
      if (s4 || load_pc) hist4.push_front(bub); else hist4.push_front(n);
      if (hist3.size() > 3) void'(hist3.pop_back());
      if (hist4.size() > 4) void'(hist4.pop_back());
`ifdef HAZ_PERF_CNT_EN
      if (s3) exp_sc3++;
      if (s4) exp_sc4++;
      if (load_pc) begin exp_fc3++; exp_fc4++; end
`endif
    end
    #1;
  endtask

  task automatic issue(input bit w, input bit [4:0] rw, input bit ld);
    drive(1'b0, 5'd0, 1'b0, 5'd0, w, rw, ld, 1'b0);
    tick();
  endtask

  task automatic drain();
    repeat (5) issue(1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
    #1;
    n_checks++;
    if ({sel3_a, sel3_b, stall3, flush3, sel4_a, sel4_b, stall4, flush4} !== 12'd0) begin
      n_fail++; $display("FAIL reset_initial: outputs=%h want 0",
                         {sel3_a, sel3_b, stall3, flush3, sel4_a, sel4_b, stall4, flush4});
    end
    tick(); tick();
    rst = 1'b0;
    issue(1, 5'd1, 0); issue(1, 5'd2, 0); issue(1, 5'd3, 0);
    drive(1, 5'd1, 1, 5'd2, 1, 5'd4, 0, 1);
    #1;
    n_checks++;
    if (sel3_a !== 2'd3 || flush3 !== 1'b1) begin
      n_fail++; $display("FAIL reset_preload: sel_a=%0d flush=%0d want 3 1", sel3_a, flush3);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sel3_a, sel3_b, stall3, flush3, sel4_a, sel4_b, stall4, flush4} !== 12'd0) begin
      n_fail++; $display("FAIL reset_mid: outputs=%h want 0",
                         {sel3_a, sel3_b, stall3, flush3, sel4_a, sel4_b, stall4, flush4});
    end
    tick();
    rst = 1'b0;
    drive(1, 5'd1, 1, 5'd2, 0, 5'd0, 0, 0);
    #1;
    n_checks++;
    if (sel3_a !== 2'd0 || sel3_b !== 2'd0 || stall3 !== 1'b0 || sel4_a !== 3'd0) begin
      n_fail++; $display("FAIL reset_release: sel3=%0d/%0d stall3=%0d sel4_a=%0d want 0",
                         sel3_a, sel3_b, stall3, sel4_a);
    end
`ifdef HAZ_PERF_CNT_EN
    n_checks++;
    if (sc3 !== 32'd0 || fc3 !== 32'd0 || sc4 !== 32'd0 || fc4 !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: %0d %0d %0d %0d want 0", sc3, fc3, sc4, fc4);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int gap = 0; gap <= 3; gap++) begin
      drain();
      issue(1, 5'd3, 0);
      repeat (gap) issue(0, 5'd0, 0);
      drive(1, 5'd3, 1, 5'd1, 1, 5'd4, 0, 0);
      #1;
      n_checks++;
      if (sel3_a !== 2'((gap < 3) ? gap + 1 : 0) || sel3_b !== 2'd0 || stall3 !== 1'b0) begin
        n_fail++; $display("FAIL b2b_gap%0d_s3: sel=%0d/%0d stall=%0d want %0d/0/0", gap,
                           sel3_a, sel3_b, stall3, (gap < 3) ? gap + 1 : 0);
      end
      n_checks++;
      if (sel4_a !== 3'(gap + 1) || stall4 !== 1'b0) begin
        n_fail++; $display("FAIL b2b_gap%0d_s4: sel=%0d stall=%0d want %0d/0", gap,
                           sel4_a, stall4, gap + 1);
      end
    end
  endtask

  task automatic test_load_use();
    drain();
    issue(1, 5'd5, 1);
    drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0);
    #1;
    n_checks++;
    if (stall3 !== 1'b1 || stall4 !== 1'b1) begin
      n_fail++; $display("FAIL load_use_c0: stall3=%0d stall4=%0d want 1 1", stall3, stall4);
    end
    tick();
    n_checks++;
    if (stall3 !== 1'b0 || sel3_a !== 2'd2 || sel3_b !== 2'd2 || stall4 !== 1'b1) begin
      n_fail++; $display("FAIL load_use_c1: stall3=%0d sel3=%0d/%0d stall4=%0d want 0 2/2 1",
                         stall3, sel3_a, sel3_b, stall4);
    end
    tick();
    n_checks++;
    if (stall4 !== 1'b0 || sel4_a !== 3'd3 || sel4_b !== 3'd3) begin
      n_fail++; $display("FAIL load_use_c2_s4: stall=%0d sel=%0d/%0d want 0 3/3",
                         stall4, sel4_a, sel4_b);
    end
    n_checks++;
    if (stall3 !== 1'b0 || sel3_a !== 2'd3) begin
      n_fail++; $display("FAIL load_use_c2_s3: stall=%0d sel=%0d want 0 3", stall3, sel3_a);
    end
  endtask

  task automatic test_youngest_wins();
    drain();
    issue(1, 5'd7, 1);
    drive(1, 5'd7, 1, 5'd1, 1, 5'd7, 0, 0);
    #1;
    n_checks++;
    if (stall3 !== 1'b1) begin
      n_fail++; $display("FAIL young_addi_stall: stall=%0d want 1", stall3);
    end
    tick();
    tick();
    drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 0, 0);
    #1;
    n_checks++;
    if (sel3_a !== 2'd1 || sel3_b !== 2'd0 || stall3 !== 1'b0) begin
      n_fail++; $display("FAIL young_or_s3: sel=%0d/%0d stall=%0d want 1/0/0",
                         sel3_a, sel3_b, stall3);
    end
    n_checks++;
    if (sel4_a !== 3'd3 || stall4 !== 1'b0) begin
      n_fail++; $display("FAIL young_or_s4: sel=%0d stall=%0d want 3/0", sel4_a, stall4);
    end
    // Load at entry 2 is within LOAD_LAT=2 but masked by the younger ALU writer.
    drain();
    issue(1, 5'd7, 1);
    drive(1, 5'd1, 0, 5'd0, 1, 5'd7, 0, 0);
    tick();
    drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 0, 0);
    #1;
    n_checks++;
    if (sel4_a !== 3'd1 || stall4 !== 1'b0) begin
      n_fail++; $display("FAIL young_mask_s4: sel=%0d stall=%0d want 1/0", sel4_a, stall4);
    end
  endtask

  task automatic test_branch_priority();
    drain();
    issue(1, 5'd5, 1);
    drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 1);
    #1;
    n_checks++;
    if (flush3 !== 1'b1 || stall3 !== 1'b0 || flush4 !== 1'b1 || stall4 !== 1'b0) begin
      n_fail++; $display("FAIL branch_prio: flush=%0d/%0d stall=%0d/%0d want 1/1 0/0",
                         flush3, flush4, stall3, stall4);
    end
    tick();
    drive(1, 5'd6, 1, 5'd5, 0, 5'd0, 0, 0);
    #1;
    n_checks++;
    if (sel3_a !== 2'd0 || sel3_b !== 2'd2 || stall3 !== 1'b0 || flush3 !== 1'b0 ||
        stall4 !== 1'b1) begin
      n_fail++; $display("FAIL branch_squash: sel3=%0d/%0d stall3=%0d flush3=%0d stall4=%0d",
                         sel3_a, sel3_b, stall3, flush3, stall4);
    end
  endtask

  task automatic test_zero_and_en();
    drain();
    issue(1, 5'd0, 0);
    drive(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
    #1;
    n_checks++;
    if (sel3_a !== 2'd0 || sel3_b !== 2'd0 || sel4_a !== 3'd0) begin
      n_fail++; $display("FAIL zero_reg: sel3=%0d/%0d sel4=%0d want 0", sel3_a, sel3_b, sel4_a);
    end
    issue(1, 5'd10, 1);
    issue(1, 5'd9, 0);
    en = 1'b0;
    drive(1, 5'd9, 1, 5'd10, 0, 5'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (sel3_a !== 2'd1 || sel3_b !== 2'd2 || stall3 !== 1'b0 || stall4 !== 1'b1) begin
        n_fail++; $display("FAIL en_hold_c%0d: sel3=%0d/%0d stall3=%0d stall4=%0d", c,
                           sel3_a, sel3_b, stall3, stall4);
      end
      tick();
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (sel3_a !== 2'd2 || sel3_b !== 2'd3 || sel4_a !== 3'd2 || sel4_b !== 3'd3 ||
        stall4 !== 1'b0) begin
      n_fail++; $display("FAIL en_resume: sel3=%0d/%0d sel4=%0d/%0d stall4=%0d want 2/3 2/3 0",
                         sel3_a, sel3_b, sel4_a, sel4_b, stall4);
    end
  endtask

  task automatic test_random();
    bit s3, s4;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      #1;
      s3 = rst ? 1'b0 : exp_stall(hist3, 3, 1);
      s4 = rst ? 1'b0 : exp_stall(hist4, 4, 2);
      n_checks++;
      if (stall3 !== s3 || flush3 !== (load_pc && !rst) || stall4 !== s4 ||
          flush4 !== (load_pc && !rst)) begin
        n_fail++; $display("FAIL rand_ctl_%0d: stall=%0d/%0d flush=%0d/%0d want %0d/%0d %0d",
                           i, stall3, stall4, flush3, flush4, s3, s4, load_pc && !rst);
      end
      if (!s3) begin
        n_checks++;
        if (sel3_a !== 2'(rst ? 0 : exp_sel(hist3, 3, id_use_a, id_req_a)) ||
            sel3_b !== 2'(rst ? 0 : exp_sel(hist3, 3, id_use_b, id_req_b))) begin
          n_fail++; $display("FAIL rand_sel3_%0d: sel=%0d/%0d want %0d/%0d", i, sel3_a, sel3_b,
                             rst ? 0 : exp_sel(hist3, 3, id_use_a, id_req_a),
                             rst ? 0 : exp_sel(hist3, 3, id_use_b, id_req_b));
        end
      end
      if (!s4) begin
        n_checks++;
        if (sel4_a !== 3'(rst ? 0 : exp_sel(hist4, 4, id_use_a, id_req_a)) ||
            sel4_b !== 3'(rst ? 0 : exp_sel(hist4, 4, id_use_b, id_req_b))) begin
          n_fail++; $display("FAIL rand_sel4_%0d: sel=%0d/%0d want %0d/%0d", i, sel4_a, sel4_b,
                             rst ? 0 : exp_sel(hist4, 4, id_use_a, id_req_a),
                             rst ? 0 : exp_sel(hist4, 4, id_use_b, id_req_b));
        end
      end
`ifdef HAZ_PERF_CNT_EN
      n_checks++;
      if (sc3 !== exp_sc3 || fc3 !== exp_fc3 || sc4 !== exp_sc4 || fc4 !== exp_fc4) begin
        n_fail++; $display("FAIL rand_cnt_%0d: %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                           sc3, fc3, sc4, fc4, exp_sc3, exp_fc3, exp_sc4, exp_fc4);
      end
`endif
      tick();
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest_wins();
    test_branch_priority();
    test_zero_and_en();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
